// File: rtl/fetch_prefetch_queue.sv
// Instruction prefetch queue: keeps up to FIFO_DEPTH fetches in flight, buffers {pc, instr}
// pairs in order, and drops stale responses after a branch/jump redirect.
module fetch_prefetch_queue #(
   parameter int unsigned           ADDR_WIDTH  = 32,
   parameter int unsigned           INSTR_WIDTH = 32,
   parameter int unsigned           FIFO_DEPTH  = 4,
   parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   redirect_valid,
   input  logic [ADDR_WIDTH-1:0]  redirect_pc,
   output logic                   imem_req_valid,
   input  logic                   imem_req_ready,
   output logic [ADDR_WIDTH-1:0]  imem_req_addr,
   input  logic                   imem_rsp_valid,
   input  logic [INSTR_WIDTH-1:0] imem_rsp_data,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [ADDR_WIDTH-1:0]  out_pc,
   output logic [INSTR_WIDTH-1:0] out_instruction
);

   localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;
   localparam int unsigned SUM_W = CNT_W + 1;

   typedef enum logic {
      RUN   = 1'b0,
      FLUSH = 1'b1
   } state_t;

   state_t                 state;
   logic [ADDR_WIDTH-1:0]  fetch_pc;
   logic [ADDR_WIDTH-1:0]  rsp_pc;
   logic [ADDR_WIDTH-1:0]  pc_mem    [FIFO_DEPTH];
   logic [INSTR_WIDTH-1:0] instr_mem [FIFO_DEPTH];
   logic [PTR_W-1:0]       rd_ptr;
   logic [PTR_W-1:0]       wr_ptr;
   logic [CNT_W-1:0]       count;
   logic [CNT_W-1:0]       outstanding;
   logic [CNT_W-1:0]       drop_cnt;
   logic [CNT_W-1:0]       drop_nxt;
   logic [ADDR_WIDTH-1:0]  redirect_tgt;
   logic                   credit_ok;
   logic                   accept;
   logic                   push;
   logic                   pop;

   assign redirect_tgt = redirect_pc & ~ADDR_WIDTH'(3);

   // Buffered entries plus in-flight requests never exceed the buffer size, so a push always fits.
   assign credit_ok = (SUM_W'(count) + SUM_W'(outstanding)) < SUM_W'(FIFO_DEPTH);

   assign imem_req_valid  = !rst && (state == RUN) && !redirect_valid && credit_ok;
   assign imem_req_addr   = fetch_pc;
   assign accept          = imem_req_valid && imem_req_ready;
   assign push            = imem_rsp_valid && (drop_cnt == '0) && !redirect_valid;
   assign out_valid       = !rst && (count != '0) && !redirect_valid;
   assign pop             = out_valid && out_ready;
   assign out_pc          = pc_mem[rd_ptr];
   assign out_instruction = instr_mem[rd_ptr];

   // Stale responses still to discard after the next edge.
   always_comb begin
      drop_nxt = drop_cnt;
      if (redirect_valid) begin
         drop_nxt = outstanding - CNT_W'(imem_rsp_valid);
      end else if (imem_rsp_valid && (drop_cnt != '0)) begin
         drop_nxt = drop_cnt - CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= RUN;
         fetch_pc    <= RESET_PC;
         rsp_pc      <= RESET_PC;
         rd_ptr      <= '0;
         wr_ptr      <= '0;
         count       <= '0;
         outstanding <= '0;
         drop_cnt    <= '0;
      end else if (redirect_valid) begin
         fetch_pc    <= redirect_tgt;
         rsp_pc      <= redirect_tgt;
         rd_ptr      <= '0;
         wr_ptr      <= '0;
         count       <= '0;
         outstanding <= outstanding - CNT_W'(imem_rsp_valid);
         drop_cnt    <= drop_nxt;
         state       <= (drop_nxt == '0) ? RUN : FLUSH;
      end else begin
         assert (!(push && (count == CNT_W'(FIFO_DEPTH))));
         if (accept) begin
            fetch_pc <= fetch_pc + ADDR_WIDTH'(4);
         end
         if (push) begin
            rsp_pc <= rsp_pc + ADDR_WIDTH'(4);
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         count       <= count + CNT_W'(push) - CNT_W'(pop);
         outstanding <= outstanding + CNT_W'(accept) - CNT_W'(imem_rsp_valid);
         drop_cnt    <= drop_nxt;
         if ((state == FLUSH) && (drop_nxt == '0)) begin
            state <= RUN;
         end
      end
   end

   // Entry storage needs no reset; validity is tracked by count.
   always_ff @(posedge clk) begin
      if (push) begin
         pc_mem[wr_ptr]    <= rsp_pc;
         instr_mem[wr_ptr] <= imem_rsp_data;
      end
   end

endmodule
